reset_trigger_gen: RTL
======================

Name: reset_trigger_gen

Overview:
- Upstream reset-request aggregator for the clock/reset generator. Drives its `trigger_reset` input.
- Merges three sources into one bounded `trigger_reset` pulse:
  - a debounced front-panel pushbutton,
  - a CSR software reset strobe,
  - a programmable watchdog.
- Records which source(s) fired in a sticky cause register that survives the resulting system reset, so boot firmware can read it.

Parameters:
- DEBOUNCE_CYCLES, 50000: cycles `btn_n` must be stable before the debounced level changes (1 ms at 50 MHz).
- WD_W, 32: watchdog counter and load width.
- WD_WARN, 1024: watchdog pre-expiry warning threshold.
- TRIG_LEN, 4: `trigger_reset` pulse length in cycles (≥1).

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous active-high reset.
- btn_n  in  1  asynchronous pushbutton, active low.
- sw_reset  in  1  one-cycle software reset request (CSR write).
- wd_en  in  1  watchdog enable (CSR level).
- wd_kick  in  1  one-cycle watchdog service strobe.
- wd_load  in  WD_W  watchdog reload value.
- cause_clr  in  1  one-cycle clear of `reset_cause`.
- trigger_reset  out  1  reset request to the clock/reset generator.
- wd_irq  out  1  watchdog near-expiry, level.
- wd_count  out  WD_W  current watchdog count.
- reset_cause  out  3  sticky {wd, btn, sw}.

Behaviour:
- Reset (`sys_rst`=1):
  - `trigger_reset`=0, FSM=IDLE, `wd_irq`=0, `wd_count`=0, watchdog disarmed.
  - Debounce counter=0; debounced level forced to 1 (pressed), so a button held through reset cannot retrigger until released and pressed again.
  - `reset_cause` is NOT affected by `sys_rst`. It powers up 0 via configuration init and is cleared only by `cause_clr`.
- Button path:
  - 2-FF synchronizer on `~btn_n` produces `btn_s`.
  - Counter increments while `btn_s` != debounced level and clears when they are equal.
  - When counter = DEBOUNCE_CYCLES-1 and still unequal: debounced level <= `btn_s`, counter <= 0.
  - Press event = debounced level 0→1 (one cycle).
- Watchdog:
  - Arm on `wd_en` rising edge (registered compare) or on `wd_kick` while `wd_en`=1: count <= `wd_load`, armed <= 1.
  - While armed and count>0: count decrements by 1 per cycle.
  - Expiry event when armed and count==0: armed <= 0.
  - `wd_en`=0: armed <= 0, count <= 0, no expiry.
  - `wd_load`=0 on arm: expiry on the cycle after arming.
  - `wd_kick` in the same cycle as count==0: kick wins, reload and no expiry.
  - `wd_irq` = armed && count < WD_WARN (registered).
- Event merge:
  - ev = {wd_expire, btn_press, `sw_reset`}.
  - Any nonzero ev in IDLE: `reset_cause` |= ev on the next edge.
  - Simultaneous sources latch all of their bits; there is no priority.
- FSM states:
  - IDLE: `trigger_reset`=0. Goes to FIRE on any ev.
  - FIRE: `trigger_reset`=1 for exactly TRIG_LEN cycles, counted by the pulse counter. Then goes to HOLD.
  - HOLD: `trigger_reset`=0. All sources are ignored and not latched. Left only via `sys_rst`.
- Latency: ev at cycle n → `trigger_reset` high in cycles n+1..n+TRIG_LEN; cause bit visible at n+1.
- Events during FIRE/HOLD are dropped; the cause is not updated.
- `cause_clr` and a new ev in the same IDLE cycle: the new ev bits are set, all others are cleared.
- `sys_rst` mid-FIRE: the pulse is truncated immediately (next edge `trigger_reset`=0).

Decomposition:
- Shared package holds:
  - state enum {IDLE, FIRE, HOLD};
  - cause bit index constants CAUSE_SW=0, CAUSE_BTN=1, CAUSE_WD=2.
- One sub-module is natural: `btn_debounce` (synchronizer + debounce counter + press edge), parameterized by DEBOUNCE_CYCLES. It is reusable for other panel buttons.
- Watchdog and FSM stay in the top.
- Expected size: ~200 lines of RTL.

Test Plan:
- Software reset: `sw_reset` pulse at cycle 10 → `trigger_reset` high cycles 11–14; `reset_cause`=3'b001; HOLD ignores a second `sw_reset` at cycle 20.
- Button debounce (DEBOUNCE_CYCLES=8):
  - `btn_n` glitch low for 5 cycles → no trigger.
  - Low for 20 cycles → one trigger, `reset_cause`=3'b010.
  - Button held through `sys_rst` → no retrigger until released ≥8 cycles and pressed again.
- Watchdog expiry:
  - `wd_load`=100, `wd_en` 0→1 at cycle 0 → `wd_count` 100 at cycle 1.
  - `wd_irq` high once count<WD_WARN.
  - Trigger rises the cycle after count reaches 0; `reset_cause`=3'b100.
- Watchdog kick race: kick asserted exactly when `wd_count`==0 → reload to `wd_load`, no trigger. Kick every 50 cycles with `wd_load`=100 → never fires.
- Simultaneous events and cause handling:
  - `sw_reset` and watchdog expiry in the same cycle → `reset_cause`=3'b101, single TRIG_LEN pulse.
  - `sys_rst` afterwards leaves `reset_cause`=3'b101.
  - `cause_clr` → 3'b000.
- Reset mid-pulse: assert `sys_rst` in the 2nd FIRE cycle → `trigger_reset` 0 next edge, FSM IDLE, `wd_count`=0.

Source files
------------

// File: rtl/reset_trigger_gen_pkg.sv
// Shared types and constants for the reset-request aggregator.
// The reset_cause bit layout is defined here so firmware headers can mirror it.
package reset_trigger_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    HOLD
  } state_t;

  localparam int CAUSE_W   = 3;
  localparam int CAUSE_SW  = 0;
  localparam int CAUSE_BTN = 1;
  localparam int CAUSE_WD  = 2;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter, one-cycle press pulse.
// Reusable for any active-low panel button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic btn_n,
  output logic btn_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             btn_s;
  logic             btn_level;
  logic [CNT_W-1:0] cnt;

  // Level resets to "pressed" so a button held through reset must be released first.
  always_ff @(posedge sys_clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (sys_rst) begin
      sync_q1   <= 1'b1;
      btn_s     <= 1'b1;
      btn_level <= 1'b1;
      cnt       <= '0;
      btn_press <= 1'b0;
    end else begin
      sync_q1   <= ~btn_n;
      btn_s     <= sync_q1;
      btn_press <= 1'b0;
      if (btn_s == btn_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        btn_level <= btn_s;
        btn_press <= btn_s;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reset_trigger_gen.sv
// Merges pushbutton, software and watchdog reset requests into one bounded
// trigger_reset pulse and keeps a sticky record of the cause across resets.
module reset_trigger_gen
  import reset_trigger_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int WD_W            = 32,
  parameter int WD_WARN         = 1024,
  parameter int TRIG_LEN        = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               btn_n,
  input  logic               sw_reset,
  input  logic               wd_en,
  input  logic               wd_kick,
  input  logic [WD_W-1:0]    wd_load,
  input  logic               cause_clr,
  output logic               trigger_reset,
  output logic               wd_irq,
  output logic [WD_W-1:0]    wd_count,
  output logic [CAUSE_W-1:0] reset_cause
);

  localparam int PULSE_W = (TRIG_LEN > 1) ? $clog2(TRIG_LEN) : 1;
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(TRIG_LEN - 1);

  logic btn_press;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .btn_n    (btn_n),
    .btn_press(btn_press)
  );

  logic            wd_en_q;
  logic            wd_armed;
  logic            wd_arm;
  logic            wd_expire;
  logic            wd_armed_nxt;
  logic [WD_W-1:0] wd_count_nxt;

  // A kick landing on count==0 re-arms instead of expiring.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wd_arm       = wd_en && (!wd_en_q || wd_kick);
    wd_expire    = wd_en && wd_armed && (wd_count == '0) && !wd_arm;
    wd_armed_nxt = wd_armed;
    wd_count_nxt = wd_count;
    if (!wd_en) begin
      wd_armed_nxt = 1'b0;
      wd_count_nxt = '0;
    end else if (wd_arm) begin
      wd_armed_nxt = 1'b1;
      wd_count_nxt = wd_load;
    end else if (wd_armed) begin
      if (wd_count != '0) wd_count_nxt = wd_count - 1'b1;
      else                wd_armed_nxt = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wd_en_q  <= 1'b0;
      wd_armed <= 1'b0;
      wd_count <= '0;
      wd_irq   <= 1'b0;
    end else begin
      wd_en_q  <= wd_en;
      wd_armed <= wd_armed_nxt;
      wd_count <= wd_count_nxt;
      wd_irq   <= wd_armed_nxt && (wd_count_nxt < WD_W'(WD_WARN));
    end
  end

  logic [CAUSE_W-1:0] ev;

  always_comb begin
    ev            = '0;
    ev[CAUSE_SW]  = sw_reset;
    ev[CAUSE_BTN] = btn_press;
    ev[CAUSE_WD]  = wd_expire;
  end

  state_t               state;
  logic [PULSE_W-1:0]   pulse_cnt;

  // HOLD is terminal until sys_rst, so one request yields exactly one pulse.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= IDLE;
      pulse_cnt     <= '0;
      trigger_reset <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|ev) begin
          state         <= FIRE;
          pulse_cnt     <= '0;
          trigger_reset <= 1'b1;
        end
        FIRE: if (pulse_cnt == PULSE_LAST) begin
          state         <= HOLD;
          trigger_reset <= 1'b0;
        end else begin
          pulse_cnt <= pulse_cnt + 1'b1;
        end
        HOLD: state <= HOLD;
        default: begin
          state         <= IDLE;
          trigger_reset <= 1'b0;
        end
      endcase
    end
  end

  logic               cause_take;
  // NOTE: deliberately outside sys_rst; the power-up value comes from the initializer.
  logic [CAUSE_W-1:0] cause_q = '0;

  assign cause_take = !sys_rst && (state == IDLE);

  always_ff @(posedge sys_clk) begin
    if (cause_clr)       cause_q <= cause_take ? ev : '0;
    else if (cause_take) cause_q <= cause_q | ev;
  end

  assign reset_cause = cause_q;

endmodule
